// File: rtl/svi_lane_reader_pkg.sv
// Shared types and helpers for the lane-bus reader: default geometry, the lane
// triple record, and lane-index arithmetic used by the dispatch pointer.
package svi_pkg;

  localparam int N_LANES_DEF = 8;
  localparam int W_DEF       = 8;
  localparam int CNT_W_DEF   = 16;
  localparam int LANE_IDX_W  = $clog2(N_LANES_DEF);

  typedef struct packed {
    logic [W_DEF-1:0] x;
    logic [W_DEF-1:0] y;
    logic [W_DEF-1:0] z;
  } lane_t;

  // Successor of a lane index on the ring of n lanes.
  function automatic int next_lane(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/svi_lane_reader_if.sv
// Lane bus between the per-lane producers / downstream consumer (master) and the
// reader (slave): per-lane offer/free handshake plus the serialised output stream.
interface svi_lane_reader_if #(
  parameter int N_LANES = 8,
  parameter int W       = 8,
  parameter int CNT_W   = 16
);

  localparam int IW = $clog2(N_LANES);

  logic [N_LANES-1:0]   i_lane_vld;
  logic [N_LANES*W-1:0] i_lane_x;
  logic [N_LANES*W-1:0] i_lane_y;
  logic [N_LANES*W-1:0] i_lane_z;
  logic [N_LANES-1:0]   o_lane_rdy;
  logic                 o_vld;
  logic                 i_rdy;
  logic [IW-1:0]        o_idx;
  logic [W-1:0]         o_a;
  logic [W-1:0]         o_b;
  logic [W-1:0]         o_c;
  logic [CNT_W-1:0]     o_cnt;

  modport master (
    output i_lane_vld, i_lane_x, i_lane_y, i_lane_z, i_rdy,
    input  o_lane_rdy, o_vld, o_idx, o_a, o_b, o_c, o_cnt
  );

  modport slave (
    input  i_lane_vld, i_lane_x, i_lane_y, i_lane_z, i_rdy,
    output o_lane_rdy, o_vld, o_idx, o_a, o_b, o_c, o_cnt
  );

endinterface

// File: rtl/svi_lane_reader_rr_arbiter.sv
// Combinational round-robin pick: first requesting lane at or after ptr, wrapping
// modulo N_LANES. The pointer register itself lives in the caller.
module svi_rr_arbiter #(
  parameter int N_LANES = 8,
  parameter int IW      = $clog2(N_LANES)
) (
  input  logic [N_LANES-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [N_LANES-1:0] gnt,
  output logic [IW-1:0]      gnt_idx,
  output logic               any
);

  int j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int i = 0; i < N_LANES; i++) begin
      j = int'(ptr) + i;
      if (j >= N_LANES) j = j - N_LANES;
      if (!any && req[j]) begin
        any     = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/svi_lane_reader.sv
// Reader end of the lane bus: one holding register per lane, round-robin dispatch
// into a single output register stage, and a wrapping delivered-word counter.
module svi_lane_reader
  import svi_pkg::*;
#(
  parameter int N_LANES = N_LANES_DEF,
  parameter int W       = W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input logic              i_clk,
  input logic              i_rst,
  svi_lane_reader_if.slave bus
);

  localparam int IW = $clog2(N_LANES);

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
  } word_t;

  logic [N_LANES-1:0] pend_p0;
  logic [N_LANES-1:0] accept;
  logic [N_LANES-1:0] take;
  word_t              hold_vec [N_LANES];

  logic [N_LANES-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_any;
  logic [IW-1:0]      ptr;
  logic               slot_free;

  logic               vld_p1;
  logic [IW-1:0]      idx_p1;
  word_t              out_p1;
  logic [CNT_W-1:0]   cnt;

  // Lane readiness depends only on registered state and reset, never on i_lane_vld.
  assign bus.o_lane_rdy = ~pend_p0 & {N_LANES{~i_rst}};
  assign accept         = bus.i_lane_vld & bus.o_lane_rdy;
  assign slot_free      = ~vld_p1 | bus.i_rdy;
  assign take           = slot_free ? gnt : '0;

  // ---- p0: per-lane holding registers ----
  for (genvar n = 0; n < N_LANES; n++) begin : g_lane
    word_t hold;

    always_ff @(posedge i_clk) begin
      if (accept[n]) begin
        hold.x <= bus.i_lane_x[n*W +: W];
        hold.y <= bus.i_lane_y[n*W +: W];
        hold.z <= bus.i_lane_z[n*W +: W];
      end
    end

    assign hold_vec[n] = hold;
  end

  // A lane cannot accept and be dispatched on the same edge, so set/clear never collide.
  always_ff @(posedge i_clk) begin
    if (i_rst) pend_p0 <= '0;
    else       pend_p0 <= (pend_p0 | accept) & ~take;
  end

  svi_rr_arbiter #(
    .N_LANES (N_LANES),
    .IW      (IW)
  ) u_arb (
    .req     (pend_p0),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // ---- p1: output register stage and dispatch pointer ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p1 <= 1'b0;
      idx_p1 <= '0;
      out_p1 <= '0;
      ptr    <= '0;
    end else if (slot_free) begin
      vld_p1 <= gnt_any;
      if (gnt_any) begin
        idx_p1 <= gnt_idx;
        out_p1 <= hold_vec[gnt_idx];
        ptr    <= IW'(next_lane(int'(gnt_idx), N_LANES));
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)                    cnt <= '0;
    else if (vld_p1 && bus.i_rdy) cnt <= cnt + 1'b1;
  end

  assign bus.o_vld = vld_p1;
  assign bus.o_idx = idx_p1;
  assign bus.o_a   = out_p1.x;
  assign bus.o_b   = out_p1.y;
  assign bus.o_c   = out_p1.z;
  assign bus.o_cnt = cnt;

endmodule

// File: tb/tb_svi_lane_reader.sv
// Self-checking bench for svi_lane_reader: directed scenarios plus randomized traffic
// compared each cycle against a behavioural model of the lane/dispatch rules.
module tb_svi_lane_reader;
  import svi_pkg::*;

  localparam int N = 8;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   lane_vld = '0;
  logic [N*W-1:0] lane_x = '0;
  logic [N*W-1:0] lane_y = '0;
  logic [N*W-1:0] lane_z = '0;
  logic           rdy = 1'b1;

  svi_lane_reader_if #(.N_LANES(N), .W(W), .CNT_W(16)) bus ();
  svi_lane_reader_if #(.N_LANES(N), .W(W), .CNT_W(4))  bus4 ();

  assign bus.i_lane_vld  = lane_vld;
  assign bus.i_lane_x    = lane_x;
  assign bus.i_lane_y    = lane_y;
  assign bus.i_lane_z    = lane_z;
  assign bus.i_rdy       = rdy;
  assign bus4.i_lane_vld = lane_vld;
  assign bus4.i_lane_x   = lane_x;
  assign bus4.i_lane_y   = lane_y;
  assign bus4.i_lane_z   = lane_z;
  assign bus4.i_rdy      = rdy;

  svi_lane_reader #(.N_LANES(N), .W(W), .CNT_W(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  svi_lane_reader #(.N_LANES(N), .W(W), .CNT_W(4)) dut4 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus4.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: which lanes hold a word, what they hold, where the ring
  // search starts, and what currently sits at the output.
  bit          m_pend [N];
  lane_t       m_data [N];
  int          m_ptr = 0;
  bit          m_vld = 0;
  int          m_idx = 0;
  lane_t       m_out = '0;
  int unsigned m_cnt = 0;

  task automatic model_edge();
    bit np [N];
    int g;
    if (rst) begin
      for (int n = 0; n < N; n++) m_pend[n] = 0;
      m_vld = 0; m_idx = 0; m_out = '0; m_cnt = 0; m_ptr = 0;
      return;
    end
    if (m_vld && rdy) m_cnt++;
    np = m_pend;
    g  = -1;
    if (!m_vld || rdy) begin
      for (int k = 0; k < N; k++)
        if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      if (g >= 0) begin
        m_out = m_data[g]; m_idx = g; m_vld = 1; np[g] = 0; m_ptr = (g + 1) % N;
      end else begin
        m_vld = 0;
      end
    end
    for (int n = 0; n < N; n++)
      if (lane_vld[n] && !m_pend[n]) begin
        np[n] = 1;
        m_data[n] = '{x: lane_x[n*W +: W], y: lane_y[n*W +: W], z: lane_z[n*W +: W]};
      end
    m_pend = np;
  endtask

  task automatic compare();
    logic [N-1:0] e_rdy;
    for (int n = 0; n < N; n++) e_rdy[n] = !rst && !m_pend[n];
    chk("lane_rdy", bus.o_lane_rdy, e_rdy);
    chk("vld", bus.o_vld, m_vld);
    chk("idx", bus.o_idx, m_idx[2:0]);
    chk("a", bus.o_a, m_out.x);
    chk("b", bus.o_b, m_out.y);
    chk("c", bus.o_c, m_out.z);
    chk("cnt", bus.o_cnt, m_cnt[15:0]);
    chk("cnt4", bus4.o_cnt, m_cnt[3:0]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b1; lane_vld = '0;
    cycle();
    rst = 1'b0;
  endtask

  logic [W-1:0] a_hold;
  logic [N-1:0] mask;
  int           seen;
  bit           done;

  initial begin
    // Reset held with every lane offering.
    rst = 1'b1; lane_vld = '1; rdy = 1'b1;
    repeat (3) begin
      cycle();
      chk("rst_lane_rdy", bus.o_lane_rdy, 0);
      chk("rst_vld", bus.o_vld, 0);
      chk("rst_cnt", bus.o_cnt, 0);
    end
    rst = 1'b0; lane_vld = '0;
    cycle();
    chk("post_rst_rdy", bus.o_lane_rdy, 8'hFF);

    // Single lane 3.
    lane_vld = 8'h08;
    lane_x[3*W +: W] = 8'hA5; lane_y[3*W +: W] = 8'h00; lane_z[3*W +: W] = 8'hFF;
    cycle();
    chk("one_lat_vld", bus.o_vld, 0);
    lane_vld = '0;
    cycle();
    chk("one_vld", bus.o_vld, 1);
    chk("one_idx", bus.o_idx, 3);
    chk("one_a", bus.o_a, 8'hA5);
    chk("one_b", bus.o_b, 8'h00);
    chk("one_c", bus.o_c, 8'hFF);
    cycle();
    chk("one_cnt", bus.o_cnt, 1);

    // All lanes on one edge, then lanes 2 and 6.
    do_reset();
    lane_vld = '1;
    for (int n = 0; n < N; n++) lane_x[n*W +: W] = W'(n);
    cycle();
    lane_vld = '0;
    for (int i = 0; i < N; i++) begin
      cycle();
      chk("all_idx", bus.o_idx, i);
      chk("all_a", bus.o_a, i);
    end
    cycle();
    chk("all_cnt", bus.o_cnt, 8);
    lane_vld = 8'h44;
    cycle();
    lane_vld = '0;
    cycle();
    chk("re_idx_first", bus.o_idx, 2);
    cycle();
    chk("re_idx_second", bus.o_idx, 6);

    // Backpressure with all eight pending.
    do_reset();
    rdy = 1'b0; lane_vld = '1;
    lane_x = {$urandom, $urandom};
    cycle();
    lane_vld = '0;
    cycle();
    a_hold = bus.o_a;
    repeat (5) begin
      cycle();
      chk("bp_vld", bus.o_vld, 1);
      chk("bp_idx", bus.o_idx, 0);
      chk("bp_a", bus.o_a, a_hold);
      chk("bp_lane_rdy", bus.o_lane_rdy[7:1], 0);
    end
    rdy = 1'b1; mask = 8'h01; seen = 1; done = 0;
    for (int t = 0; t < 20 && !done; t++) begin
      cycle();
      if (bus.o_vld) begin mask[bus.o_idx] = 1'b1; seen++; end
      else done = 1;
    end
    chk("bp_drained", done, 1);
    chk("bp_mask", mask, 8'hFF);
    chk("bp_words", seen, 8);
    chk("bp_cnt", bus.o_cnt, 8);

    // Fairness between lanes 0 and 7, continuing into a counter wrap.
    do_reset();
    rdy = 1'b1; lane_vld = 8'h81;
    cycle();
    for (int s = 0; s < 4; s++) begin
      cycle();
      chk("fair_idx", bus.o_idx, (s % 2) ? 7 : 0);
    end
    for (int t = 0; t < 40 && m_cnt < 17; t++) cycle();
    chk("wrap_cnt16", bus.o_cnt, 17);
    chk("wrap_cnt4", bus4.o_cnt, 1);

    // Reset while words are pending and one is in flight.
    do_reset();
    rdy = 1'b0; lane_vld = 8'h0F;
    cycle();
    lane_vld = '0;
    cycle();
    chk("mr_pre_vld", bus.o_vld, 1);
    rst = 1'b1;
    cycle();
    chk("mr_vld", bus.o_vld, 0);
    chk("mr_lane_rdy", bus.o_lane_rdy, 0);
    chk("mr_cnt", bus.o_cnt, 0);
    rst = 1'b0;
    cycle();
    chk("mr_vld_after", bus.o_vld, 0);
    chk("mr_rdy_after", bus.o_lane_rdy, 8'hFF);

    // Randomized traffic, backpressure and occasional reset.
    for (int t = 0; t < 3000; t++) begin
      lane_vld = N'($urandom);
      lane_x   = {$urandom, $urandom};
      lane_y   = {$urandom, $urandom};
      lane_z   = {$urandom, $urandom};
      rdy      = ($urandom_range(3) != 0);
      rst      = ($urandom_range(99) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
